reservation_station_alu_ordered: RTL and testbench
==================================================

Name: reservation_station_alu_ordered

Overview:
- Parametrised ALU reservation station: buffers renamed ALU ops, snoops NUM_WB writeback buses for operand wakeup, issues the oldest ready op to the combinational arithmetic_logic_unit (ports a, b, op, result).
- Output goes through a registered result stage with a valid/ready handshake.
- Successor to the fixed 16-entry station: adds age-ordered issue, back-pressure, flush, and configurable depth, width, tag width and writeback port count.

Parameters:
- DEPTH, 16: entry count, >=2.
- XLEN, 32: operand/result width.
- TAG_W, 5: virtual register tag width, <= XLEN.
- NUM_WB, 3: number of snooped writeback ports.

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous and active-low.
- flush  in  1: synchronous squash of all state.
- in_valid  in  1: new op offered.
- in_ready  out  1: station can accept.
- in_op  in  5: ALU opcode.
- in_tag  in  TAG_W: destination tag.
- in_op1_dep  in  1: op1 is a pending tag, not a value.
- in_op1  in  XLEN: value, or tag in [TAG_W-1:0].
- in_op2_dep  in  1: as op1.
- in_op2  in  XLEN: as op1.
- wb_en  in  NUM_WB: per-port writeback valid.
- wb_tag  in  NUM_WB*TAG_W: port i at [i*TAG_W +: TAG_W].
- wb_val  in  NUM_WB*XLEN: port i at [i*XLEN +: XLEN].
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts result.
- out_tag  out  TAG_W: result destination tag.
- out_val  out  XLEN: ALU result.
- count  out  $clog2(DEPTH+1): occupied entries.

Behaviour:
- Reset (rst_n=0, async): all entries invalid; count=0; out_valid=0; out_tag=0; out_val=0. in_ready=1 after release.
- Storage: collapsing queue. Entry 0 is the oldest. Valid entries are always contiguous in 0..count-1.
- in_ready = (count != DEPTH), registered-state based; it does not depend on a same-cycle issue. Accept = in_valid && in_ready.
- Entry ready = valid && !op1_dep && !op2_dep.
- Select = lowest-index ready entry (oldest first), using registered state only.
- Issue when a ready entry exists and the result stage is free: out_valid==0 || out_ready==1.
- On issue of entry k:
  - Entries k+1..count-1 shift down by one in the same edge.
  - out_valid<=1, out_tag<=entry tag, out_val<=ALU result.
- Result stage handshake:
  - out_valid && out_ready with no issue: out_valid<=0.
  - out_valid && !out_ready: out_tag and out_val hold stable.
- Enqueue write slot: index count-1 if issuing this cycle, else index count. count updates by +accept-issue.
- Wakeup:
  - Every valid dependent operand compares its stored tag against all wb ports each cycle.
  - On a match: clear the dep bit and load wb_val.
  - Multiple matching ports: the lowest port index wins.
  - Wakeup applies to entries moving during a shift.
- Incoming op capture: dependent operands of an accepted op also compare against the current-cycle wb ports and capture on a match. No op is lost to a same-cycle writeback.
- Woken operands become issue-eligible the next cycle.
- Latency without bypass: op accepted at edge N with ready operands is issued at edge N+1; out_valid is high after N+1.
- flush=1:
  - Next edge: all entries invalid, count=0, out_valid=0.
  - A same-cycle accept is dropped and a same-cycle issue is dropped.
  - flush has priority over all other updates.
- Reset mid-operation: drops everything immediately, same as flush.
- Full boundary: at count==DEPTH, in_ready=0 even if an issue occurs that cycle. An in_valid that stalls is not accepted.
- Empty boundary: count==0 gives no issue; out_valid only drains.
- No fatal or assertion on select. A select of a non-ready entry is structurally impossible.

Optional Feature:
- Macro RS_BYPASS_EN.
- When defined: an accepted op with both operands non-dependent (after same-cycle wb capture) issues directly at the accept edge without occupying an entry, when all three hold:
  - no queued entry is ready;
  - the result stage is free;
  - flush=0.
  - ALU inputs are muxed from in_*. count is unchanged. out_valid is set at the accept edge (latency 1).
- When undefined: every accepted op is enqueued; minimum latency is 2 edges.

Test Plan:
- Reset, then accept op ADD op1=5 op2=7 tag=3 with out_ready=1 -> out_valid, out_tag=3, out_val=12. Expected at edge 2, or edge 1 with RS_BYPASS_EN. count returns to 0.
- Age order:
  - Enqueue A (tag 1, op1 dep on tag 9), then B (tag 2, ready).
  - Next cycle pulse wb_en[0] tag 9 val 4.
  - Expect B issued first; after A wakes, A issues second. No reordering among two simultaneously ready entries: oldest first.
- Fill DEPTH=16 dependent ops -> in_ready=0 at count=16. Wake entry 5 -> it issues, entries shift, count=15, in_ready=1 next cycle.
- Back-pressure: hold out_ready=0 with 3 ready ops -> one result held stable with out_val unchanged, count stays 2. Raise out_ready -> one result per cycle, back-to-back.
- Same-cycle capture: accept op with op1_dep tag 6 while wb_en[2] tag 6 val 0x55 and wb_en[1] tag 6 val 0x11 -> stored operand is 0x11 (lowest port wins); op issues next cycle.
- flush asserted with 4 entries and out_valid=1, plus a simultaneous accept -> count=0 and out_valid=0 next edge. A later wb for the old tags causes no issue. Async rst_n low mid-cycle gives the same result immediately.

Source files
------------

// File: rtl/reservation_station_alu_ordered.sv
// Age-ordered ALU reservation station: a collapsing queue with writeback snooping and a registered result stage.
// Optional macro RS_BYPASS_EN lets a fully ready op issue at its accept edge without entering the queue.
module arithmetic_logic_unit #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    output logic [XLEN-1:0] result
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHW-1:0]         shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = a_s >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end
endmodule

module reservation_station_alu_ordered #(
    parameter int DEPTH  = 16,
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int NUM_WB = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_op1_dep,
    input  logic [XLEN-1:0]            in_op1,
    input  logic                       in_op2_dep,
    input  logic [XLEN-1:0]            in_op2,
    input  logic [NUM_WB-1:0]          wb_en,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    input  logic [NUM_WB*XLEN-1:0]     wb_val,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [XLEN-1:0]            out_val,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Returns {dep, value}; scanning high to low lets the lowest matching port win.
    function automatic logic [XLEN:0] wake_operand(
        input logic                    dep,
        input logic [XLEN-1:0]         v,
        input logic [NUM_WB-1:0]       en,
        input logic [NUM_WB*TAG_W-1:0] tags,
        input logic [NUM_WB*XLEN-1:0]  vals
    );
        logic [XLEN:0] r;
        r = {dep, v};
        if (dep) begin
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (en[p] && (tags[p*TAG_W +: TAG_W] == v[TAG_W-1:0])) begin
                    r = {1'b0, vals[p*XLEN +: XLEN]};
                end
            end
        end
        return r;
    endfunction

    logic [4:0]       op_q   [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic             dep1_q [DEPTH];
    logic             dep2_q [DEPTH];
    logic [XLEN-1:0]  v1_q   [DEPTH];
    logic [XLEN-1:0]  v2_q   [DEPTH];
    logic [4:0]       op_d   [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];
    logic             dep1_d [DEPTH];
    logic             dep2_d [DEPTH];
    logic [XLEN-1:0]  v1_d   [DEPTH];
    logic [XLEN-1:0]  v2_d   [DEPTH];
    logic             w_dep1 [DEPTH];
    logic             w_dep2 [DEPTH];
    logic [XLEN-1:0]  w_v1   [DEPTH];
    logic [XLEN-1:0]  w_v2   [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [XLEN-1:0]  out_val_q, out_val_d;

    logic             in_dep1_w, in_dep2_w;
    logic [XLEN-1:0]  in_v1_w, in_v2_w;
    logic             any_ready;
    logic [IW-1:0]    sel;
    logic             stage_free, issue, accept, bypass, enq;
    logic [CW-1:0]    wr_idx;
    logic [XLEN-1:0]  alu_a, alu_b, alu_result;
    logic [4:0]       alu_op;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {w_dep1[i], w_v1[i]} = wake_operand(dep1_q[i], v1_q[i], wb_en, wb_tag, wb_val);
            {w_dep2[i], w_v2[i]} = wake_operand(dep2_q[i], v2_q[i], wb_en, wb_tag, wb_val);
        end
        {in_dep1_w, in_v1_w} = wake_operand(in_op1_dep, in_op1, wb_en, wb_tag, wb_val);
        {in_dep2_w, in_v2_w} = wake_operand(in_op2_dep, in_op2, wb_en, wb_tag, wb_val);
    end

    // Oldest-first select over registered state only; wakeups seen this cycle count next cycle.
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count_q) && !dep1_q[i] && !dep2_q[i]) begin
                any_ready = 1'b1;
                sel       = IW'(i);
            end
        end
    end

    assign in_ready   = (count_q != CW'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign stage_free = !out_valid_q || out_ready;
    assign issue      = any_ready && stage_free;

`ifdef RS_BYPASS_EN
    assign bypass = accept && !in_dep1_w && !in_dep2_w && !any_ready && stage_free && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign enq    = accept && !bypass;
    assign alu_a  = bypass ? in_v1_w : v1_q[sel];
    assign alu_b  = bypass ? in_v2_w : v2_q[sel];
    assign alu_op = bypass ? in_op   : op_q[sel];

    arithmetic_logic_unit #(.XLEN(XLEN)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    // Entries above the issued slot collapse down, carrying their wakeups with them.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            op_d[i]   = op_q[i];
            tag_d[i]  = tag_q[i];
            dep1_d[i] = w_dep1[i];
            v1_d[i]   = w_v1[i];
            dep2_d[i] = w_dep2[i];
            v2_d[i]   = w_v2[i];
        end
        if (issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= sel) begin
                    op_d[i]   = op_q[i+1];
                    tag_d[i]  = tag_q[i+1];
                    dep1_d[i] = w_dep1[i+1];
                    v1_d[i]   = w_v1[i+1];
                    dep2_d[i] = w_dep2[i+1];
                    v2_d[i]   = w_v2[i+1];
                end
            end
        end
        wr_idx = issue ? (count_q - CW'(1)) : count_q;
        if (enq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    op_d[i]   = in_op;
                    tag_d[i]  = in_tag;
                    dep1_d[i] = in_dep1_w;
                    v1_d[i]   = in_v1_w;
                    dep2_d[i] = in_dep2_w;
                    v2_d[i]   = in_v2_w;
                end
            end
        end
    end

    always_comb begin
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_val_d   = out_val_q;
        if (flush) begin
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            count_d = count_q + CW'(enq) - CW'(issue);
            if (issue || bypass) begin
                out_valid_d = 1'b1;
                out_tag_d   = bypass ? in_tag : tag_q[sel];
                out_val_d   = alu_result;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Control state and the result stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_val_q   <= '0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_val_q   <= out_val_d;
        end
    end

    // Entry payload; occupancy is defined by count alone, so the payload needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= op_d[i];
            tag_q[i]  <= tag_d[i];
            dep1_q[i] <= dep1_d[i];
            v1_q[i]   <= v1_d[i];
            dep2_q[i] <= dep2_d[i];
            v2_q[i]   <= v2_d[i];
        end
    end

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_val   = out_val_q;
    assign count     = count_q;
endmodule

// File: tb/tb_reservation_station_alu_ordered.sv
// Directed bench for reservation_station_alu_ordered with a result scoreboard checked on each output handshake.
module tb_reservation_station_alu_ordered;
    localparam int DEPTH  = 16;
    localparam int XLEN   = 32;
    localparam int TAG_W  = 5;
    localparam int NUM_WB = 3;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam logic [4:0] ADD = 5'd0;
    localparam logic [4:0] SUB = 5'd1;
    localparam logic [4:0] XOR = 5'd4;

    logic                    clk, rst_n, flush;
    logic                    in_valid, in_ready;
    logic [4:0]              in_op;
    logic [TAG_W-1:0]        in_tag;
    logic                    in_op1_dep, in_op2_dep;
    logic [XLEN-1:0]         in_op1, in_op2;
    logic [NUM_WB-1:0]       wb_en;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_val;
    logic                    out_valid, out_ready;
    logic [TAG_W-1:0]        out_tag;
    logic [XLEN-1:0]         out_val;
    logic [CW-1:0]           count;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    reservation_station_alu_ordered #(
        .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .NUM_WB(NUM_WB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
        .in_op1_dep(in_op1_dep), .in_op1(in_op1), .in_op2_dep(in_op2_dep), .in_op2(in_op2),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_val(wb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_val(out_val),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] op, input logic [TAG_W-1:0] tag,
                       input logic d1, input logic [XLEN-1:0] a,
                       input logic d2, input logic [XLEN-1:0] b);
        in_valid   = 1'b1;
        in_op      = op;
        in_tag     = tag;
        in_op1_dep = d1;
        in_op1     = a;
        in_op2_dep = d2;
        in_op2     = b;
    endtask

    task automatic wbp(input int p, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        wb_en[p]                  = 1'b1;
        wb_tag[p*TAG_W +: TAG_W] = t;
        wb_val[p*XLEN +: XLEN]   = v;
    endtask

    task automatic expect_res(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        sb.push_back({t, v});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // A result transfers on the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed tag=0x%0h val=0x%0h expected=none", out_tag, out_val);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_out_tag", 64'(out_tag), 64'(e.tag));
                chk("sb_out_val", 64'(out_val), 64'(e.val));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_tag = '0;
        in_op1_dep = 1'b0; in_op1 = '0; in_op2_dep = 1'b0; in_op2 = '0;
        wb_en = '0; wb_tag = '0; wb_val = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_val", 64'(out_val), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic latency: ADD 5+7 -> tag 3
        out_ready = 1'b1;
        put(ADD, 5'd3, 1'b0, 32'd5, 1'b0, 32'd7);
        expect_res(5'd3, 32'd12);
        tick();
        in_valid = 1'b0;
`ifdef RS_BYPASS_EN
        chk("lat_valid_e1", 64'(out_valid), 64'd1);
`else
        chk("lat_valid_e1", 64'(out_valid), 64'd0);
        chk("lat_count_e1", 64'(count), 64'd1);
        tick();
        chk("lat_valid_e2", 64'(out_valid), 64'd1);
`endif
        chk("lat_out_tag", 64'(out_tag), 64'd3);
        chk("lat_count_end", 64'(count), 64'd0);
        drain(5);
        chk("lat_idle", 64'(out_valid), 64'd0);

        // Age order: younger ready B overtakes blocked A
        put(ADD, 5'd1, 1'b1, 32'd9, 1'b0, 32'd10);
        tick();
        put(ADD, 5'd2, 1'b0, 32'd20, 1'b0, 32'd3);
        expect_res(5'd2, 32'd23);
        expect_res(5'd1, 32'd14);
        tick();
        in_valid = 1'b0;
        wbp(0, 5'd9, 32'd4);
        tick();
        wb_en = '0;
        drain(10);

        // Two entries woken together issue oldest first
        put(XOR, 5'd4, 1'b1, 32'd11, 1'b0, 32'hF0);
        tick();
        put(SUB, 5'd5, 1'b1, 32'd12, 1'b0, 32'd5);
        tick();
        in_valid = 1'b0;
        expect_res(5'd4, 32'hF1);
        expect_res(5'd5, 32'hFFFF_FFFD);
        wbp(0, 5'd11, 32'd1);
        wbp(1, 5'd12, 32'd2);
        tick();
        wb_en = '0;
        drain(10);

        // Fill to DEPTH with dependent ops, then wake from the middle
        for (int i = 0; i < DEPTH; i++) begin
            put(ADD, TAG_W'(i), 1'b1, 32'(16 + i), 1'b0, 32'(100 + i));
            tick();
        end
        in_valid = 1'b0;
        chk("full_count", 64'(count), 64'd16);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        put(ADD, 5'd30, 1'b0, 32'd1, 1'b0, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("full_stall_count", 64'(count), 64'd16);
        expect_res(5'd5, 32'd112);
        wbp(0, 5'd21, 32'd7);
        tick();
        wb_en = '0;
        chk("full_wake_count", 64'(count), 64'd16);
        chk("full_wake_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("full_issue_count", 64'(count), 64'd15);
        chk("full_issue_in_ready", 64'(in_ready), 64'd1);
        chk("full_issue_tag", 64'(out_tag), 64'd5);
        expect_res(5'd6, 32'd107);
        expect_res(5'd15, 32'd117);
        wbp(0, 5'd22, 32'd1);
        wbp(1, 5'd31, 32'd2);
        tick();
        wb_en = '0;
        drain(10);
        chk("shift_count", 64'(count), 64'd13);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fill_flush_count", 64'(count), 64'd0);

        // Back-pressure: first result held, then back-to-back drain
        out_ready = 1'b0;
        put(ADD, 5'd7, 1'b0, 32'd1, 1'b0, 32'd1);
        expect_res(5'd7, 32'd2);
        tick();
        put(ADD, 5'd8, 1'b0, 32'd2, 1'b0, 32'd2);
        expect_res(5'd8, 32'd4);
        tick();
        put(ADD, 5'd9, 1'b0, 32'd3, 1'b0, 32'd3);
        expect_res(5'd9, 32'd6);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_tag", 64'(out_tag), 64'd7);
            chk("bp_val", 64'(out_val), 64'd2);
            chk("bp_count", 64'(count), 64'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("b2b_tag8", 64'(out_tag), 64'd8);
        chk("b2b_valid8", 64'(out_valid), 64'd1);
        tick();
        chk("b2b_tag9", 64'(out_tag), 64'd9);
        chk("b2b_valid9", 64'(out_valid), 64'd1);
        tick();
        chk("b2b_done", 64'(out_valid), 64'd0);
        chk("b2b_count", 64'(count), 64'd0);

        // Same-cycle capture at accept: port 1 beats port 2
        put(ADD, 5'd10, 1'b1, 32'd6, 1'b0, 32'h100);
        wbp(1, 5'd6, 32'h11);
        wbp(2, 5'd6, 32'h55);
        expect_res(5'd10, 32'h111);
        tick();
        in_valid = 1'b0;
        wb_en = '0;
`ifndef RS_BYPASS_EN
        chk("cap_count", 64'(count), 64'd1);
        tick();
`endif
        chk("cap_valid", 64'(out_valid), 64'd1);
        chk("cap_tag", 64'(out_tag), 64'd10);
        drain(5);

        // Flush with a held result, four waiting entries and a simultaneous accept
        out_ready = 1'b0;
        put(ADD, 5'd20, 1'b0, 32'd1, 1'b0, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            put(ADD, TAG_W'(21 + i), 1'b1, 32'(25 + i), 1'b0, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_flush_count", 64'(count), 64'd4);
        chk("pre_flush_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        put(ADD, 5'd29, 1'b0, 32'd1, 1'b0, 32'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        wbp(0, 5'd25, 32'd1);
        wbp(1, 5'd26, 32'd1);
        wbp(2, 5'd27, 32'd1);
        tick();
        wb_en = '0;
        wbp(0, 5'd28, 32'd1);
        tick();
        wb_en = '0;
        repeat (3) tick();
        chk("post_flush_valid", 64'(out_valid), 64'd0);
        chk("post_flush_count", 64'(count), 64'd0);

        // Asynchronous reset in the middle of a cycle
        out_ready = 1'b0;
        put(ADD, 5'd11, 1'b0, 32'd1, 1'b0, 32'd2);
        tick();
        put(ADD, 5'd12, 1'b1, 32'd3, 1'b0, 32'd0);
        tick();
        put(ADD, 5'd13, 1'b1, 32'd4, 1'b0, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        chk("arst_val", 64'(out_val), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        wbp(0, 5'd3, 32'd1);
        wbp(1, 5'd4, 32'd1);
        tick();
        wb_en = '0;
        repeat (2) tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_count", 64'(count), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
